subtrator_serial_10bit: RTL

//  Multi-cycle bit-serial subtractor: computes d = a - b (mod 2^WIDTH) plus a

---
 rtl/soma_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 17 +
 rtl/subtrator_serial_10bit.sv | 119 +++++++++++
 3 files changed

// File: rtl/soma_pkg.sv
// Shared definitions for the serial arithmetic datapath: FSM encoding,
// default operand width and the bit-counter width helper.
package soma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 10;

  // Counter indexes bits 0..WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Gate-level companion of the ripple adder's full_adder cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/subtrator_serial_10bit.sv
// Bit-serial subtractor d = a - b (mod 2^WIDTH), LSB first, one bit per clock
// behind a start/done handshake. Define SUB_SIGNED_OVF_EN to add the ovf output.
module subtrator_serial_10bit
  import soma_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 low result bits; the final bit goes straight into d.
  logic [WIDTH-2:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             bin_ff;
  logic             diff_k;
  logic             bout_k;
`ifdef SUB_SIGNED_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_ff),
    .d    (diff_k),
    .bout (bout_k)
  );

  // NOTE: every register, shift registers included, is reset so an aborted
  // operation leaves no partial operand or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      bin_ff <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      borrow <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the shift registers and counter.
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            bin_ff <= 1'b0;
            busy   <= 1'b1;
            state  <= ST_BUSY;
`ifdef SUB_SIGNED_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end

        ST_BUSY: begin
          res_sr <= {diff_k, res_sr[WIDTH-2:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          bin_ff <= bout_k;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            d      <= {diff_k, res_sr};
            borrow <= bout_k;
`ifdef SUB_SIGNED_OVF_EN
            // diff_k is the result MSB on the last bit.
            ovf    <= (a_msb != b_msb) && (diff_k != a_msb);
`endif
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
